// File: rtl/commit_trace_checker_if.sv
// Bundle for the commit trace checker: the expected-record load channel
// and the live CPU commit event lines.
//
// Load handshake: a record transfers on a rising clock edge where
// exp_valid && exp_ready. exp_valid and the exp_* fields are held stable
// until that edge. exp_ready never depends on exp_valid.
// Commit events are sampled only on edges where check_en is high.
interface commit_trace_checker_if;
  logic        exp_valid;
  logic        exp_ready;
  logic [1:0]  exp_kind;
  logic [3:0]  exp_reg;
  logic [15:0] exp_addr;
  logic [15:0] exp_data;
  logic        exp_done;
  logic        check_en;
  logic        obs_reg_write;
  logic [3:0]  obs_reg;
  logic [15:0] obs_reg_data;
  logic        obs_mem_write;
  logic [15:0] obs_mem_addr;
  logic [15:0] obs_mem_data;
  logic        obs_halt;

  // Loader and CPU side
  modport master (
    output exp_valid, exp_kind, exp_reg, exp_addr, exp_data, exp_done,
    output check_en, obs_reg_write, obs_reg, obs_reg_data,
    output obs_mem_write, obs_mem_addr, obs_mem_data, obs_halt,
    input  exp_ready
  );

  // Checker side
  modport slave (
    input  exp_valid, exp_kind, exp_reg, exp_addr, exp_data, exp_done,
    input  check_en, obs_reg_write, obs_reg, obs_reg_data,
    input  obs_mem_write, obs_mem_addr, obs_mem_data, obs_halt,
    output exp_ready
  );
endinterface

// File: rtl/commit_trace_checker.sv
// Commit trace checker: buffers expected commit records and observed CPU
// commit events in two FIFOs and compares them in order, one pair per
// cycle. Records are packed {kind[1:0], reg[3:0], addr[15:0], data[15:0]}.
// Ends in a terminal PASS (HALT matched) or FAIL state with sticky details.
module commit_trace_checker #(
  parameter int EXP_DEPTH = 16,
  parameter int OBS_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  commit_trace_checker_if.slave        bus,
  output logic                         pass,
  output logic                         fail,
  output logic [1:0]                   err_code,
  output logic [15:0]                  match_count,
  output logic [37:0]                  err_exp,
  output logic [37:0]                  err_obs,
  output logic [1:0]                   state_o,
  output logic [$clog2(EXP_DEPTH):0]   exp_level_o,
  output logic [$clog2(OBS_DEPTH):0]   obs_level_o
);

  localparam int EAW = $clog2(EXP_DEPTH);
  localparam int OAW = $clog2(OBS_DEPTH);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_FAIL = 2'd2;

  localparam logic [1:0] KIND_REG   = 2'b00;
  localparam logic [1:0] KIND_STORE = 2'b01;
  localparam logic [1:0] KIND_HALT  = 2'b10;

  localparam logic [EAW:0] EXP_FULL_LVL = (EAW+1)'(EXP_DEPTH);
  localparam logic [OAW:0] OBS_FULL_LVL = (OAW+1)'(OBS_DEPTH);

  // State and status registers
  logic [1:0]  state_q, state_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [15:0] match_q, match_d;
  logic [37:0] err_exp_q, err_exp_d;
  logic [37:0] err_obs_q, err_obs_d;

  // FIFO storage and pointers (one extra bit distinguishes full from empty)
  logic [37:0] exp_mem [EXP_DEPTH];
  logic [37:0] obs_mem [OBS_DEPTH];
  logic [EAW:0] exp_wptr_q, exp_rptr_q;
  logic [OAW:0] obs_wptr_q, obs_rptr_q;

  logic [EAW:0] exp_lvl;
  logic [OAW:0] obs_lvl, obs_after_pop, obs_free;
  logic         exp_empty, exp_full, obs_empty;
  logic         run;
  logic         exp_push, do_cmp, obs_push, overflow, extra;
  logic [1:0]   n_ev, ev_idx;
  logic [37:0]  obs_rec [4];
  logic [37:0]  exp_head, obs_head, exp_in;
  logic         rec_match;

  assign run       = (state_q == ST_RUN);
  assign exp_lvl   = exp_wptr_q - exp_rptr_q;
  assign obs_lvl   = obs_wptr_q - obs_rptr_q;
  assign exp_empty = (exp_lvl == '0);
  assign exp_full  = (exp_lvl == EXP_FULL_LVL);
  assign obs_empty = (obs_lvl == '0);

  assign bus.exp_ready = run && !exp_full;
  assign exp_push      = run && bus.exp_valid && !exp_full;
  assign exp_in        = {bus.exp_kind, bus.exp_reg, bus.exp_addr, bus.exp_data};

  assign exp_head = exp_mem[exp_rptr_q[EAW-1:0]];
  assign obs_head = obs_mem[obs_rptr_q[OAW-1:0]];

  // Both FIFOs pop together whenever a pair is available
  assign do_cmp = run && !exp_empty && !obs_empty;

  // Slots freed by this edge's pop count toward room for new events
  assign obs_after_pop = obs_lvl - (OAW+1)'(do_cmp);
  assign obs_free      = OBS_FULL_LVL - obs_after_pop;
  assign n_ev = {1'b0, bus.obs_reg_write} + {1'b0, bus.obs_mem_write} + {1'b0, bus.obs_halt};
  assign overflow = run && bus.check_en && ((OAW+1)'(n_ev) > obs_free);
  assign obs_push = run && bus.check_en && (n_ev != 2'd0) && !overflow;

  assign extra = run && bus.exp_done && exp_empty && !obs_empty;

  // Pack this cycle's events in REG, STORE, HALT order into consecutive slots
  always_comb begin
    for (int k = 0; k < 4; k++) obs_rec[k] = '0;
    ev_idx = 2'd0;
    if (bus.obs_reg_write) begin
      obs_rec[ev_idx] = {KIND_REG, bus.obs_reg, 16'h0000, bus.obs_reg_data};
      ev_idx = ev_idx + 2'd1;
    end
    if (bus.obs_mem_write) begin
      obs_rec[ev_idx] = {KIND_STORE, 4'h0, bus.obs_mem_addr, bus.obs_mem_data};
      ev_idx = ev_idx + 2'd1;
    end
    if (bus.obs_halt) begin
      obs_rec[ev_idx] = {KIND_HALT, 36'h0};
    end
  end

  // Field comparison by kind; the illegal kind never matches
  always_comb begin
    rec_match = 1'b0;
    if (exp_head[37:36] == obs_head[37:36]) begin
      unique case (exp_head[37:36])
        KIND_REG:   rec_match = (exp_head[35:32] == obs_head[35:32]) &&
                                (exp_head[15:0] == obs_head[15:0]);
        KIND_STORE: rec_match = (exp_head[31:16] == obs_head[31:16]) &&
                                (exp_head[15:0] == obs_head[15:0]);
        KIND_HALT:  rec_match = 1'b1;
        default:    rec_match = 1'b0;
      endcase
    end
  end

  // Next-state and status: overflow beats compare result beats extra event
  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    err_code_d = err_code_q;
    match_d    = match_q;
    err_exp_d  = err_exp_q;
    err_obs_d  = err_obs_q;
    if (overflow) begin
      state_d    = ST_FAIL;
      fail_d     = 1'b1;
      err_code_d = 2'd3;
    end else if (do_cmp) begin
      if (rec_match) begin
        if (match_q != 16'hFFFF) match_d = match_q + 16'd1;
        if (exp_head[37:36] == KIND_HALT) begin
          state_d = ST_PASS;
          pass_d  = 1'b1;
        end
      end else begin
        state_d    = ST_FAIL;
        fail_d     = 1'b1;
        err_code_d = 2'd1;
        err_exp_d  = exp_head;
        err_obs_d  = obs_head;
      end
    end else if (extra) begin
      state_d    = ST_FAIL;
      fail_d     = 1'b1;
      err_code_d = 2'd2;
      err_exp_d  = '0;
      err_obs_d  = obs_head;
    end
  end

  // Control registers and FIFO pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      err_code_q <= 2'd0;
      match_q    <= 16'd0;
      err_exp_q  <= '0;
      err_obs_q  <= '0;
      exp_wptr_q <= '0;
      exp_rptr_q <= '0;
      obs_wptr_q <= '0;
      obs_rptr_q <= '0;
    end else begin
      state_q    <= state_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      err_code_q <= err_code_d;
      match_q    <= match_d;
      err_exp_q  <= err_exp_d;
      err_obs_q  <= err_obs_d;
      if (exp_push) exp_wptr_q <= exp_wptr_q + (EAW+1)'(1);
      if (do_cmp) begin
        exp_rptr_q <= exp_rptr_q + (EAW+1)'(1);
        obs_rptr_q <= obs_rptr_q + (OAW+1)'(1);
      end
      if (obs_push) obs_wptr_q <= obs_wptr_q + (OAW+1)'(n_ev);
    end
  end

  // FIFO storage writes (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (exp_push) exp_mem[exp_wptr_q[EAW-1:0]] <= exp_in;
    if (obs_push) begin
      for (int k = 0; k < 3; k++) begin
        if (k < int'(n_ev)) obs_mem[OAW'(obs_wptr_q + (OAW+1)'(k))] <= obs_rec[k];
      end
    end
  end

  assign pass        = pass_q;
  assign fail        = fail_q;
  assign err_code    = err_code_q;
  assign match_count = match_q;
  assign err_exp     = err_exp_q;
  assign err_obs     = err_obs_q;
  assign state_o     = state_q;
  assign exp_level_o = exp_lvl;
  assign obs_level_o = obs_lvl;

endmodule

// File: tb/tb_commit_trace_checker.sv
// Directed bench for commit_trace_checker: load expected records, drive
// commit events, and compare status outputs with hand-computed values.
module tb_commit_trace_checker;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_FAIL = 2'd2;

  logic        clk;
  logic        rst_n;
  logic        pass, fail;
  logic [1:0]  err_code;
  logic [15:0] match_count;
  logic [37:0] err_exp, err_obs;
  logic [1:0]  state_o;
  logic [4:0]  exp_level_o;
  logic [3:0]  obs_level_o;

  int n_checks = 0;
  int n_fail   = 0;

  commit_trace_checker_if bus_if ();

  commit_trace_checker #(.EXP_DEPTH(16), .OBS_DEPTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_if.slave),
    .pass        (pass),
    .fail        (fail),
    .err_code    (err_code),
    .match_count (match_count),
    .err_exp     (err_exp),
    .err_obs     (err_obs),
    .state_o     (state_o),
    .exp_level_o (exp_level_o),
    .obs_level_o (obs_level_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus_if.exp_valid     = 1'b0;
    bus_if.exp_kind      = 2'b00;
    bus_if.exp_reg       = 4'h0;
    bus_if.exp_addr      = 16'h0;
    bus_if.exp_data      = 16'h0;
    bus_if.check_en      = 1'b0;
    bus_if.obs_reg_write = 1'b0;
    bus_if.obs_reg       = 4'h0;
    bus_if.obs_reg_data  = 16'h0;
    bus_if.obs_mem_write = 1'b0;
    bus_if.obs_mem_addr  = 16'h0;
    bus_if.obs_mem_data  = 16'h0;
    bus_if.obs_halt      = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    bus_if.exp_done = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] kind, input logic [3:0] r,
                          input logic [15:0] addr, input logic [15:0] data);
    bus_if.exp_valid = 1'b1;
    bus_if.exp_kind  = kind;
    bus_if.exp_reg   = r;
    bus_if.exp_addr  = addr;
    bus_if.exp_data  = data;
    @(posedge clk);
    #1 bus_if.exp_valid = 1'b0;
  endtask

  task automatic obs_cycle(input logic rw, input logic [3:0] r, input logic [15:0] rd,
                           input logic mw, input logic [15:0] ma, input logic [15:0] md,
                           input logic h);
    bus_if.check_en      = 1'b1;
    bus_if.obs_reg_write = rw;
    bus_if.obs_reg       = r;
    bus_if.obs_reg_data  = rd;
    bus_if.obs_mem_write = mw;
    bus_if.obs_mem_addr  = ma;
    bus_if.obs_mem_data  = md;
    bus_if.obs_halt      = h;
    @(posedge clk);
    #1 clear_inputs();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pass"},   64'(pass), 64'd0);
    check({tag, "_fail"},   64'(fail), 64'd0);
    check({tag, "_err"},    64'(err_code), 64'd0);
    check({tag, "_match"},  64'(match_count), 64'd0);
    check({tag, "_errexp"}, 64'(err_exp), 64'd0);
    check({tag, "_errobs"}, 64'(err_obs), 64'd0);
    check({tag, "_rdy"},    64'(bus_if.exp_ready), 64'd1);
    check({tag, "_state"},  64'(state_o), 64'(ST_RUN));
  endtask

  initial begin
    // T0: reset state
    do_reset();
    check_reset_outputs("rst");
    check("rst_explvl", 64'(exp_level_o), 64'd0);
    check("rst_obslvl", 64'(obs_level_o), 64'd0);

    // T1: REG, STORE, HALT on separate cycles -> PASS
    push_exp(2'b00, 4'd3, 16'h0000, 16'h0005);
    push_exp(2'b01, 4'd0, 16'h0010, 16'h0005);
    push_exp(2'b10, 4'd0, 16'h0000, 16'h0000);
    bus_if.exp_done = 1'b1;
    check("t1_explvl", 64'(exp_level_o), 64'd3);
    obs_cycle(1'b1, 4'd3, 16'h0005, 1'b0, 16'h0, 16'h0, 1'b0);
    obs_cycle(1'b0, 4'd0, 16'h0, 1'b1, 16'h0010, 16'h0005, 1'b0);
    obs_cycle(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1);
    check("t1_pass_early", 64'(pass), 64'd0);
    check("t1_match_early", 64'(match_count), 64'd2);
    idle(1);
    check("t1_pass", 64'(pass), 64'd1);
    check("t1_fail", 64'(fail), 64'd0);
    check("t1_match", 64'(match_count), 64'd3);
    check("t1_state", 64'(state_o), 64'(ST_PASS));
    check("t1_rdy", 64'(bus_if.exp_ready), 64'd0);
    idle(2);
    check("t1_pass_hold", 64'(pass), 64'd1);

    // T2a: REG + STORE in one cycle, expected in the same order
    do_reset();
    push_exp(2'b00, 4'd1, 16'h0000, 16'h00AA);
    push_exp(2'b01, 4'd0, 16'h0020, 16'h1234);
    obs_cycle(1'b1, 4'd1, 16'h00AA, 1'b1, 16'h0020, 16'h1234, 1'b0);
    check("t2a_obslvl", 64'(obs_level_o), 64'd2);
    idle(2);
    check("t2a_match", 64'(match_count), 64'd2);
    check("t2a_fail", 64'(fail), 64'd0);
    check("t2a_state", 64'(state_o), 64'(ST_RUN));
    check("t2a_obslvl_after", 64'(obs_level_o), 64'd0);

    // T2b: expected order reversed -> mismatch on the first pair
    do_reset();
    push_exp(2'b01, 4'd0, 16'h0020, 16'h1234);
    push_exp(2'b00, 4'd1, 16'h0000, 16'h00AA);
    obs_cycle(1'b1, 4'd1, 16'h00AA, 1'b1, 16'h0020, 16'h1234, 1'b0);
    idle(1);
    check("t2b_fail", 64'(fail), 64'd1);
    check("t2b_err", 64'(err_code), 64'd1);
    check("t2b_expkind", 64'(err_exp[37:36]), 64'd1);
    check("t2b_errexp", 64'(err_exp), 64'({2'b01, 4'h0, 16'h0020, 16'h1234}));
    check("t2b_errobs", 64'(err_obs), 64'({2'b00, 4'h1, 16'h0000, 16'h00AA}));
    check("t2b_match", 64'(match_count), 64'd0);

    // T3: data mismatch on a REG record
    do_reset();
    push_exp(2'b00, 4'd2, 16'h0000, 16'h0007);
    obs_cycle(1'b1, 4'd2, 16'h0008, 1'b0, 16'h0, 16'h0, 1'b0);
    check("t3_fail_early", 64'(fail), 64'd0);
    idle(1);
    check("t3_fail", 64'(fail), 64'd1);
    check("t3_err", 64'(err_code), 64'd1);
    check("t3_obsdata", 64'(err_obs[15:0]), 64'h0008);
    check("t3_expdata", 64'(err_exp[15:0]), 64'h0007);
    check("t3_rdy", 64'(bus_if.exp_ready), 64'd0);
    push_exp(2'b00, 4'd5, 16'h0000, 16'h0001);
    idle(1);
    check("t3_rdy_hold", 64'(bus_if.exp_ready), 64'd0);
    check("t3_explvl_frozen", 64'(exp_level_o), 64'd0);
    check("t3_pass", 64'(pass), 64'd0);

    // T4: three events per cycle with nothing expected -> third cycle overflows
    do_reset();
    obs_cycle(1'b1, 4'd1, 16'h0001, 1'b1, 16'h0002, 16'h0003, 1'b1);
    obs_cycle(1'b1, 4'd1, 16'h0001, 1'b1, 16'h0002, 16'h0003, 1'b1);
    check("t4_lvl6", 64'(obs_level_o), 64'd6);
    check("t4_state_run", 64'(state_o), 64'(ST_RUN));
    obs_cycle(1'b1, 4'd1, 16'h0001, 1'b1, 16'h0002, 16'h0003, 1'b1);
    check("t4_fail", 64'(fail), 64'd1);
    check("t4_err", 64'(err_code), 64'd3);
    check("t4_lvl_after", 64'(obs_level_o), 64'd6);
    check("t4_errexp", 64'(err_exp), 64'd0);
    check("t4_errobs", 64'(err_obs), 64'd0);

    // T5: one expected REG, two observed -> match then extra event
    do_reset();
    push_exp(2'b00, 4'd4, 16'h0000, 16'h0011);
    bus_if.exp_done = 1'b1;
    obs_cycle(1'b1, 4'd4, 16'h0011, 1'b0, 16'h0, 16'h0, 1'b0);
    obs_cycle(1'b1, 4'd4, 16'h0022, 1'b0, 16'h0, 16'h0, 1'b0);
    check("t5_match_first", 64'(match_count), 64'd1);
    check("t5_state_run", 64'(state_o), 64'(ST_RUN));
    idle(1);
    check("t5_fail", 64'(fail), 64'd1);
    check("t5_err", 64'(err_code), 64'd2);
    check("t5_match", 64'(match_count), 64'd1);
    check("t5_errobs", 64'(err_obs), 64'({2'b00, 4'h4, 16'h0000, 16'h0022}));
    check("t5_errexp", 64'(err_exp), 64'd0);

    // T6: fill expected FIFO, then reset mid-stream
    do_reset();
    for (int i = 0; i < 16; i++) push_exp(2'b00, 4'(i), 16'h0000, 16'(i));
    check("t6_full_rdy", 64'(bus_if.exp_ready), 64'd0);
    check("t6_full_lvl", 64'(exp_level_o), 64'd16);
    push_exp(2'b00, 4'd0, 16'h0000, 16'hFFFF);
    check("t6_full_hold", 64'(exp_level_o), 64'd16);
    obs_cycle(1'b1, 4'd0, 16'h0000, 1'b0, 16'h0, 16'h0, 1'b0);
    idle(1);
    check("t6_match", 64'(match_count), 64'd1);
    check("t6_rdy_freed", 64'(bus_if.exp_ready), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    check("t6_async_lvl", 64'(exp_level_o), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("t6_post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got no_finish expected finish");
    $fatal(1, "time limit reached");
  end

endmodule
